tri_persp_div: RTL and testbench

Perspective-divide and viewport stage between `geoshader` and the rasteriser. It accepts one clipped clip-space triangle at a time, computes 1/w per vertex with an iterative divider, and produces NDC x/y/z. It then maps x/y to screen-space and z to [0,1] depth, and presents the result to the rasteriser on a valid/ready handshake. Triangles with any w ≤ 0 are dropped and flagged.

---
 rtl/tri_persp_div.sv | 196 +++++++++++++++++++
 tb/tb_tri_persp_div.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/tri_persp_div.sv
// Perspective divide and viewport map for one clip-space triangle at a time.
// An iterative divider builds 1/w per vertex; each vertex then gets NDC and screen space.
//
// state | meaning
// IDLE  | ready for a triangle; a triangle with any w <= 0 is dropped here
// DIV   | 32-cycle restoring divide 2^32 / w[k] -> rw[k]
// NDC   | x, y, z scaled by rw[k], saturated
// VP    | viewport map of vertex k, next vertex or finish
// OUT   | result held for the rasteriser until out_ready_i
module tri_persp_div #(
   parameter int VERTEX_WIDTH = 32
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic                    in_valid_i,
   output logic                    in_ready_o,
   input  logic [VERTEX_WIDTH-1:0] v0_x_i,
   input  logic [VERTEX_WIDTH-1:0] v0_y_i,
   input  logic [VERTEX_WIDTH-1:0] v0_z_i,
   input  logic [VERTEX_WIDTH-1:0] v0_w_i,
   input  logic [VERTEX_WIDTH-1:0] v1_x_i,
   input  logic [VERTEX_WIDTH-1:0] v1_y_i,
   input  logic [VERTEX_WIDTH-1:0] v1_z_i,
   input  logic [VERTEX_WIDTH-1:0] v1_w_i,
   input  logic [VERTEX_WIDTH-1:0] v2_x_i,
   input  logic [VERTEX_WIDTH-1:0] v2_y_i,
   input  logic [VERTEX_WIDTH-1:0] v2_z_i,
   input  logic [VERTEX_WIDTH-1:0] v2_w_i,
   input  logic [VERTEX_WIDTH-1:0] vp_x_i,
   input  logic [VERTEX_WIDTH-1:0] vp_y_i,
   input  logic [VERTEX_WIDTH-1:0] vp_hw_i,
   input  logic [VERTEX_WIDTH-1:0] vp_hh_i,
   output logic                    out_valid_o,
   input  logic                    out_ready_i,
   output logic [VERTEX_WIDTH-1:0] out_sx_o [3],
   output logic [VERTEX_WIDTH-1:0] out_sy_o [3],
   output logic [VERTEX_WIDTH-1:0] out_sz_o [3],
   output logic [VERTEX_WIDTH-1:0] out_rw_o [3],
   output logic                    drop_o
);

   typedef enum logic [2:0] {S_IDLE, S_DIV, S_NDC, S_VP, S_OUT} state_t;

   state_t      r_state;
   logic [1:0]  r_k;
   logic [4:0]  r_cnt;
   logic [31:0] r_rem;
   logic [30:0] r_quo;
   logic [31:0] r_x [3], r_y [3], r_z [3], r_w [3];
   logic [31:0] r_vpx, r_vpy, r_hw, r_hh;
   logic [31:0] r_nx, r_ny, r_nz;
   logic [31:0] r_rw [3], r_sx [3], r_sy [3], r_sz [3];
   logic        r_drop, r_out_valid;

   function automatic logic [31:0] sat32(input logic signed [63:0] v);
      if (v > 64'sh7FFF_FFFF)
         return 32'h7FFF_FFFF;
      else if (v < -64'sh8000_0000)
         return 32'h8000_0000;
      else
         return v[31:0];
   endfunction

   // Q16.16 x Q16.16 -> Q16.16, kept 64 bits wide so callers can saturate
   function automatic logic signed [63:0] mulq(input logic [31:0] a, input logic [31:0] b);
      logic signed [63:0] ea, eb, p;
      ea = {{32{a[31]}}, a};
      eb = {{32{b[31]}}, b};
      p  = ea * eb;
      return p >>> 16;
   endfunction

   logic [31:0] w_wk;
   logic [32:0] w_rem_sh;
   logic        w_ge;
   logic [31:0] w_rem_nx;
   logic        w_div_sat;
   logic        w_any_nonpos;
   logic [31:0] w_nx, w_ny, w_nz, w_sx, w_sy, w_sz;
   logic [32:0] w_sz33;

   always_comb begin
      w_wk         = r_w[r_k];
      w_rem_sh     = {r_rem, 1'b0};
      w_ge         = (w_rem_sh >= {1'b0, w_wk});
      w_rem_nx     = w_ge ? 32'(w_rem_sh - {1'b0, w_wk}) : w_rem_sh[31:0];
      w_div_sat    = (w_wk <= 32'd2);
      w_any_nonpos = v0_w_i[31] || (v0_w_i == '0) || v1_w_i[31] || (v1_w_i == '0)
                  || v2_w_i[31] || (v2_w_i == '0);
      w_nx         = sat32(mulq(r_x[r_k], r_rw[r_k]));
      w_ny         = sat32(mulq(r_y[r_k], r_rw[r_k]));
      w_nz         = sat32(mulq(r_z[r_k], r_rw[r_k]));
      w_sx         = sat32($signed({{32{r_vpx[31]}}, r_vpx}) + mulq(r_nx, r_hw));
      w_sy         = sat32($signed({{32{r_vpy[31]}}, r_vpy}) - mulq(r_ny, r_hh));
      w_sz33       = {r_nz[31], r_nz} + 33'h0_0001_0000;
      w_sz         = 32'(w_sz33 >> 1);
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_state     <= S_IDLE;
         r_k         <= '0;
         r_cnt       <= '0;
         r_rem       <= '0;
         r_quo       <= '0;
         r_vpx       <= '0;
         r_vpy       <= '0;
         r_hw        <= '0;
         r_hh        <= '0;
         r_nx        <= '0;
         r_ny        <= '0;
         r_nz        <= '0;
         r_drop      <= 1'b0;
         r_out_valid <= 1'b0;
         for (int i = 0; i < 3; i++) begin
            r_x[i]  <= '0;
            r_y[i]  <= '0;
            r_z[i]  <= '0;
            r_w[i]  <= '0;
            r_rw[i] <= '0;
            r_sx[i] <= '0;
            r_sy[i] <= '0;
            r_sz[i] <= '0;
         end
      end else begin
         r_drop <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (in_valid_i) begin
                  r_x[0] <= v0_x_i;  r_y[0] <= v0_y_i;  r_z[0] <= v0_z_i;  r_w[0] <= v0_w_i;
                  r_x[1] <= v1_x_i;  r_y[1] <= v1_y_i;  r_z[1] <= v1_z_i;  r_w[1] <= v1_w_i;
                  r_x[2] <= v2_x_i;  r_y[2] <= v2_y_i;  r_z[2] <= v2_z_i;  r_w[2] <= v2_w_i;
                  r_vpx  <= vp_x_i;
                  r_vpy  <= vp_y_i;
                  r_hw   <= vp_hw_i;
                  r_hh   <= vp_hh_i;
                  if (w_any_nonpos) begin
                     r_drop <= 1'b1;
                  end else begin
                     r_k     <= 2'd0;
                     r_cnt   <= 5'd31;
                     r_rem   <= 32'd1;
                     r_state <= S_DIV;
                  end
               end
            end
            S_DIV: begin
               // dividend is 2^32: its top bit seeds the remainder, then zeros shift in
               r_rem <= w_rem_nx;
               r_quo <= {r_quo[29:0], w_ge};
               r_cnt <= r_cnt - 5'd1;
               if (r_cnt == 5'd0) begin
                  r_rw[r_k] <= w_div_sat ? 32'h7FFF_FFFF : {r_quo, w_ge};
                  r_state   <= S_NDC;
               end
            end
            S_NDC: begin
               r_nx    <= w_nx;
               r_ny    <= w_ny;
               r_nz    <= w_nz;
               r_state <= S_VP;
            end
            S_VP: begin
               r_sx[r_k] <= w_sx;
               r_sy[r_k] <= w_sy;
               r_sz[r_k] <= w_sz;
               if (r_k == 2'd2) begin
                  r_out_valid <= 1'b1;
                  r_state     <= S_OUT;
               end else begin
                  r_k     <= r_k + 2'd1;
                  r_cnt   <= 5'd31;
                  r_rem   <= 32'd1;
                  r_state <= S_DIV;
               end
            end
            S_OUT: begin
               if (out_ready_i) begin
                  r_out_valid <= 1'b0;
                  r_state     <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign in_ready_o  = (r_state == S_IDLE);
   assign out_valid_o = r_out_valid;
   assign drop_o      = r_drop;
   assign out_sx_o    = r_sx;
   assign out_sy_o    = r_sy;
   assign out_sz_o    = r_sz;
   assign out_rw_o    = r_rw;

endmodule

// File: tb/tb_tri_persp_div.sv
// Directed bench for tri_persp_div: a table of vertices with hand-computed results,
// plus hand-written reject, back-pressure and mid-run reset sequences.
module tb_tri_persp_div;

   logic        clk = 1'b0;
   logic        rst_ni = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] vx [3], vy [3], vz [3], vw [3];
   logic [31:0] vpx, vpy, vhw, vhh;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] o_sx [3], o_sy [3], o_sz [3], o_rw [3];
   logic        drop;

   int n_chk  = 0;
   int n_pass = 0;

   localparam logic [31:0] VPX = 32'h0140_0000;
   localparam logic [31:0] VPY = 32'h00F0_0000;
   localparam logic [31:0] VHW = 32'h0140_0000;
   localparam logic [31:0] VHH = 32'h00F0_0000;

   typedef struct {
      logic [31:0] x, y, z, w;
      logic [31:0] rw, sx, sy, sz;
   } vec_t;
   vec_t tab [8];

   tri_persp_div #(.VERTEX_WIDTH(32)) dut (
      .clk_i(clk), .rst_ni(rst_ni),
      .in_valid_i(in_valid), .in_ready_o(in_ready),
      .v0_x_i(vx[0]), .v0_y_i(vy[0]), .v0_z_i(vz[0]), .v0_w_i(vw[0]),
      .v1_x_i(vx[1]), .v1_y_i(vy[1]), .v1_z_i(vz[1]), .v1_w_i(vw[1]),
      .v2_x_i(vx[2]), .v2_y_i(vy[2]), .v2_z_i(vz[2]), .v2_w_i(vw[2]),
      .vp_x_i(vpx), .vp_y_i(vpy), .vp_hw_i(vhw), .vp_hh_i(vhh),
      .out_valid_o(out_valid), .out_ready_i(out_ready),
      .out_sx_o(o_sx), .out_sy_o(o_sy), .out_sz_o(o_sz), .out_rw_o(o_rw),
      .drop_o(drop)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp)
         $display("FAIL %s: actual %h required %h", name, act, exp);
      else
         n_pass++;
   endtask

   task automatic set_vp();
      vpx = VPX; vpy = VPY; vhw = VHW; vhh = VHH;
   endtask

   task automatic scramble_vp();
      vpx = $urandom; vpy = $urandom; vhw = $urandom; vhh = $urandom;
   endtask

   task automatic load(input int a, input int b, input int c);
      int idx [3];
      idx[0] = a; idx[1] = b; idx[2] = c;
      for (int v = 0; v < 3; v++) begin
         vx[v] = tab[idx[v]].x; vy[v] = tab[idx[v]].y;
         vz[v] = tab[idx[v]].z; vw[v] = tab[idx[v]].w;
      end
   endtask

   task automatic check_outs(input int a, input int b, input int c, input string tag);
      int idx [3];
      idx[0] = a; idx[1] = b; idx[2] = c;
      for (int v = 0; v < 3; v++) begin
         check($sformatf("%s v%0d rw", tag, v), o_rw[v], tab[idx[v]].rw);
         check($sformatf("%s v%0d sx", tag, v), o_sx[v], tab[idx[v]].sx);
         check($sformatf("%s v%0d sy", tag, v), o_sy[v], tab[idx[v]].sy);
         check($sformatf("%s v%0d sz", tag, v), o_sz[v], tab[idx[v]].sz);
      end
   endtask

   // call one cycle after the accepting edge; returns cycles from accept to out_valid
   task automatic wait_out(output int lat, output logic busy_ok);
      lat = 1;
      busy_ok = 1'b1;
      while (!out_valid && lat < 300) begin
         if (in_ready !== 1'b0) busy_ok = 1'b0;
         tick();
         lat++;
      end
   endtask

   task automatic run_tri(input int a, input int b, input int c, input string tag);
      int   lat;
      logic busy_ok;
      load(a, b, c);
      set_vp();
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      scramble_vp();
      wait_out(lat, busy_ok);
      check({tag, " latency"}, 32'(lat), 32'd103);
      check({tag, " in_ready low while busy"}, {31'b0, busy_ok}, 32'd1);
      check_outs(a, b, c, tag);
      tick();
      check({tag, " out_valid after transfer"}, {31'b0, out_valid}, 32'd0);
      check({tag, " in_ready after transfer"}, {31'b0, in_ready}, 32'd1);
   endtask

   initial begin
      int   lat;
      logic busy_ok;
      logic seen;
      logic [31:0] bad_w [3];

      //        x             y             z             w             rw            sx            sy            sz
      tab[0] = '{32'h0000_8000, 32'h0000_8000, 32'h0000_0000, 32'h0001_0000, 32'h0001_0000, 32'h01E0_0000, 32'h0078_0000, 32'h0000_8000};
      tab[1] = '{32'h0002_0000, 32'hFFFE_0000, 32'h0001_0000, 32'h0002_0000, 32'h0000_8000, 32'h0280_0000, 32'h01E0_0000, 32'h0000_C000};
      tab[2] = '{32'h0002_0000, 32'hFFFE_0000, 32'h0002_0000, 32'h0002_0000, 32'h0000_8000, 32'h0280_0000, 32'h01E0_0000, 32'h0001_0000};
      tab[3] = '{32'h0001_0000, 32'hFFFF_0000, 32'h0002_0000, 32'h0000_0001, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h4000_7FFF};
      tab[4] = '{32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0002, 32'h7FFF_FFFF, 32'h0140_0000, 32'h00F0_0000, 32'h0000_8000};
      tab[5] = '{32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0003, 32'h5555_5555, 32'h0140_0000, 32'h00F0_0000, 32'h0000_8000};
      tab[6] = '{32'hFFFF_0000, 32'h0003_0000, 32'hFFFF_0000, 32'h0004_0000, 32'h0000_4000, 32'h00F0_0000, 32'h003C_0000, 32'h0000_6000};
      tab[7] = '{32'hFFFF_0000, 32'h0001_0000, 32'h0000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 32'h8000_0000, 32'h8000_0000, 32'h0000_8000};

      load(0, 0, 0);
      set_vp();
      tick();
      tick();
      rst_ni = 1'b1;
      check("reset in_ready", {31'b0, in_ready}, 32'd1);
      check("reset out_valid", {31'b0, out_valid}, 32'd0);
      check("reset drop", {31'b0, drop}, 32'd0);
      check("reset sx0", o_sx[0], 32'd0);
      check("reset rw2", o_rw[2], 32'd0);

      run_tri(0, 0, 0, "single");
      for (int i = 0; i < 8; i++)
         run_tri(i, (i + 1) % 8, (i + 2) % 8, $sformatf("tab%0d", i));

      // rejects: negative, zero and most-negative w on different vertices
      bad_w[0] = 32'hFFFF_0000; bad_w[1] = 32'h0000_0000; bad_w[2] = 32'h8000_0000;
      for (int i = 0; i < 3; i++) begin
         load(0, 0, 0);
         vw[(i + 1) % 3] = bad_w[i];
         set_vp();
         in_valid = 1'b1;
         tick();
         in_valid = 1'b0;
         check($sformatf("reject%0d drop", i), {31'b0, drop}, 32'd1);
         check($sformatf("reject%0d in_ready", i), {31'b0, in_ready}, 32'd1);
         check($sformatf("reject%0d out_valid", i), {31'b0, out_valid}, 32'd0);
         tick();
         check($sformatf("reject%0d drop one cycle", i), {31'b0, drop}, 32'd0);
         check($sformatf("reject%0d no output", i), {31'b0, out_valid}, 32'd0);
      end

      // reject immediately followed by an accepted triangle
      load(0, 0, 0);
      vw[1] = 32'hFFFF_0000;
      set_vp();
      in_valid = 1'b1;
      tick();
      check("b2b drop", {31'b0, drop}, 32'd1);
      load(1, 6, 0);
      tick();
      in_valid = 1'b0;
      check("b2b accepted", {31'b0, in_ready}, 32'd0);
      check("b2b drop cleared", {31'b0, drop}, 32'd0);
      wait_out(lat, busy_ok);
      check("b2b latency", 32'(lat), 32'd103);
      check_outs(1, 6, 0, "b2b");
      tick();

      // back-pressure with input and viewport activity during OUT
      out_ready = 1'b0;
      load(6, 0, 3);
      set_vp();
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      wait_out(lat, busy_ok);
      check("bp latency", 32'(lat), 32'd103);
      for (int c = 0; c < 20; c++) begin
         in_valid = c[0];
         scramble_vp();
         load(c % 8, 2, 4);
         tick();
         check_outs(6, 0, 3, $sformatf("bp c%0d", c));
         check($sformatf("bp c%0d out_valid", c), {31'b0, out_valid}, 32'd1);
         check($sformatf("bp c%0d in_ready", c), {31'b0, in_ready}, 32'd0);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      tick();
      check("bp transfer", {31'b0, out_valid}, 32'd0);
      check("bp idle", {31'b0, in_ready}, 32'd1);

      // reset in the middle of the second vertex's divide
      load(0, 1, 2);
      set_vp();
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      for (int c = 0; c < 50; c++) tick();
      rst_ni = 1'b0;
      tick();
      rst_ni = 1'b1;
      check("rst in_ready", {31'b0, in_ready}, 32'd1);
      check("rst out_valid", {31'b0, out_valid}, 32'd0);
      check("rst drop", {31'b0, drop}, 32'd0);
      check("rst rw0 cleared", o_rw[0], 32'd0);
      check("rst sx0 cleared", o_sx[0], 32'd0);
      seen = 1'b0;
      for (int c = 0; c < 120; c++) begin
         tick();
         if (out_valid || drop) seen = 1'b1;
      end
      check("rst no output", {31'b0, seen}, 32'd0);
      run_tri(2, 5, 7, "after_rst");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
